// File: rtl/cfs_irq_collector_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cfs_irq_collector_if : event, status-clear, enable and interrupt bundle.
// Rev 1.0
// ----------------------------------------------------------------------------
interface cfs_irq_collector_if #(
  parameter int NUM_IRQ = 5,
  parameter int CNT_W   = 8
);
  logic [NUM_IRQ-1:0]       event_in;
  logic                     clr_valid;
  logic [NUM_IRQ-1:0]       clr_data;
  logic                     en_valid;
  logic [NUM_IRQ-1:0]       en_data;
  logic [NUM_IRQ-1:0]       irq_status;
  logic [NUM_IRQ-1:0]       irq_en;
  logic                     irq;
  logic [NUM_IRQ*CNT_W-1:0] event_cnt;

  modport master (
    output event_in, clr_valid, clr_data, en_valid, en_data,
    input  irq_status, irq_en, irq, event_cnt
  );

  modport slave (
    input  event_in, clr_valid, clr_data, en_valid, en_data,
    output irq_status, irq_en, irq, event_cnt
  );
endinterface
`default_nettype wire

// File: rtl/cfs_irq_collector.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cfs_irq_collector : sticky event status, enable mask and hold-off level irq.
// Optional per-source event counters when CFS_IRQ_EVENT_CNT_EN is defined.
// Rev 1.0
// ----------------------------------------------------------------------------
module cfs_irq_collector #(
  parameter int NUM_IRQ        = 5,
  parameter int HOLDOFF_CYCLES = 4,
  parameter int CNT_W          = 8
) (
  input wire logic           clk,
  input wire logic           reset,
  cfs_irq_collector_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ASSERT  = 2'd1,
    S_HOLDOFF = 2'd2
  } state_t;

  localparam logic [7:0] c_HOLD_LOAD =
    (HOLDOFF_CYCLES == 0) ? 8'd0 : 8'(HOLDOFF_CYCLES - 1);

  logic [NUM_IRQ-1:0] r_status;
  logic [NUM_IRQ-1:0] r_en;
  logic               r_irq;
  state_t             r_state;
  state_t             w_next_state;
  logic [7:0]         r_hold_cnt;
  logic [7:0]         w_next_cnt;
  logic [NUM_IRQ-1:0] w_clr_mask;
  logic               w_pending;

  assign w_clr_mask = bus.clr_valid ? bus.clr_data : '0;
  assign w_pending  = |(r_status & r_en);

  // Set term is OR-ed last so a coincident event beats its own clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_status <= '0;
      r_en     <= '0;
    end else begin
      r_status <= (r_status & ~w_clr_mask) | bus.event_in;
      if (bus.en_valid) begin
        r_en <= bus.en_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_hold_cnt <= 8'd0;
      r_irq      <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_hold_cnt <= w_next_cnt;
      r_irq      <= (w_next_state == S_ASSERT);
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_hold_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_pending) begin
          w_next_state = S_ASSERT;
        end
      end
      S_ASSERT: begin
        if (!w_pending) begin
          if (HOLDOFF_CYCLES == 0) begin
            w_next_state = S_IDLE;
          end else begin
            w_next_state = S_HOLDOFF;
            w_next_cnt   = c_HOLD_LOAD;
          end
        end
      end
      S_HOLDOFF: begin
        if (r_hold_cnt == 8'd0) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_cnt = r_hold_cnt - 8'd1;
        end
      end
      default: begin
        w_next_state = S_IDLE;
        w_next_cnt   = 8'd0;
      end
    endcase
  end

  assign bus.irq_status = r_status;
  assign bus.irq_en     = r_en;
  assign bus.irq        = r_irq;

`ifdef CFS_IRQ_EVENT_CNT_EN
  genvar gi;
  generate
    for (gi = 0; gi < NUM_IRQ; gi++) begin : g_cnt
      logic [CNT_W-1:0] r_cnt;

      // Counters saturate; a W1C restarts the count, keeping a same-cycle event.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_cnt <= '0;
        end else if (bus.clr_valid && bus.clr_data[gi]) begin
          r_cnt <= bus.event_in[gi] ? CNT_W'(1) : '0;
        end else if (bus.event_in[gi] && (r_cnt != {CNT_W{1'b1}})) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end

      assign bus.event_cnt[gi*CNT_W +: CNT_W] = r_cnt;
    end
  endgenerate
`else
  assign bus.event_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cfs_irq_collector.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_cfs_irq_collector : directed self-checking bench for cfs_irq_collector.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_cfs_irq_collector;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  cfs_irq_collector_if #(.NUM_IRQ(5), .CNT_W(8)) bus ();

  cfs_irq_collector #(
    .NUM_IRQ        (5),
    .HOLDOFF_CYCLES (4),
    .CNT_W          (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic idle_inputs();
    bus.event_in  = '0;
    bus.clr_valid = 1'b0;
    bus.clr_data  = '0;
    bus.en_valid  = 1'b0;
    bus.en_data   = '0;
  endtask

  task automatic write_en(input logic [4:0] val);
    bus.en_valid = 1'b1;
    bus.en_data  = val;
    tick();
    bus.en_valid = 1'b0;
    bus.en_data  = '0;
  endtask

  // Clear every status bit and outwait any hold-off so the FSM is back in IDLE.
  task automatic quiesce();
    idle_inputs();
    write_en(5'b00000);
    bus.clr_valid = 1'b1;
    bus.clr_data  = 5'b11111;
    tick();
    idle_inputs();
    tick(8);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    tick(2);
    reset = 1'b0;
    n_vec++; if (bus.irq_status !== 5'b0) begin n_err++; $display("FAIL reset_status got=%b exp=%b", bus.irq_status, 5'b0); end
    n_vec++; if (bus.irq_en !== 5'b0) begin n_err++; $display("FAIL reset_en got=%b exp=%b", bus.irq_en, 5'b0); end
    n_vec++; if (bus.irq !== 1'b0) begin n_err++; $display("FAIL reset_irq got=%b exp=0", bus.irq); end
    n_vec++; if (bus.event_cnt !== 40'h0) begin n_err++; $display("FAIL reset_cnt got=%h exp=0", bus.event_cnt); end
  endtask

  task automatic test_basic();
    write_en(5'b00001);
    n_vec++; if (bus.irq_en !== 5'b00001) begin n_err++; $display("FAIL basic_en got=%b exp=00001", bus.irq_en); end
    bus.event_in = 5'b00001;
    tick();
    bus.event_in = 5'b00000;
    n_vec++; if (bus.irq_status !== 5'b00001) begin n_err++; $display("FAIL basic_status got=%b exp=00001", bus.irq_status); end
    n_vec++; if (bus.irq !== 1'b0) begin n_err++; $display("FAIL basic_irq_t1 got=%b exp=0", bus.irq); end
    tick();
    n_vec++; if (bus.irq !== 1'b1) begin n_err++; $display("FAIL basic_irq_t2 got=%b exp=1", bus.irq); end
    quiesce();
  endtask

  task automatic test_enable_late();
    bus.event_in = 5'b01000;
    tick();
    bus.event_in = 5'b00000;
    n_vec++; if (bus.irq_status !== 5'b01000) begin n_err++; $display("FAIL late_status got=%b exp=01000", bus.irq_status); end
    tick();
    n_vec++; if (bus.irq !== 1'b0) begin n_err++; $display("FAIL late_irq_masked got=%b exp=0", bus.irq); end
    write_en(5'b01000);
    n_vec++; if (bus.irq !== 1'b0) begin n_err++; $display("FAIL late_irq_w1 got=%b exp=0", bus.irq); end
    tick();
    n_vec++; if (bus.irq !== 1'b1) begin n_err++; $display("FAIL late_irq_w2 got=%b exp=1", bus.irq); end
    quiesce();
  endtask

  task automatic test_holdoff();
    logic [6:0] exp_irq;
    write_en(5'b00001);
    bus.event_in = 5'b00001;
    tick();
    bus.event_in = 5'b00000;
    tick();
    n_vec++; if (bus.irq !== 1'b1) begin n_err++; $display("FAIL hold_pre_irq got=%b exp=1", bus.irq); end
    bus.clr_valid = 1'b1;
    bus.clr_data  = 5'b00001;
    tick();
    idle_inputs();
    n_vec++; if (bus.irq_status !== 5'b00000) begin n_err++; $display("FAIL hold_cleared got=%b exp=00000", bus.irq_status); end
    // irq still 1 here (clear edge), then 4 hold-off cycles, one IDLE cycle, then reassert.
    exp_irq = 7'b1000001;
    n_vec++; if (bus.irq !== exp_irq[0]) begin n_err++; $display("FAIL hold_irq_k0 got=%b exp=%b", bus.irq, exp_irq[0]); end
    for (int c = 1; c <= 6; c++) begin
      bus.event_in = (c == 2) ? 5'b00001 : 5'b00000;
      tick();
      n_vec++; if (bus.irq !== exp_irq[c]) begin n_err++; $display("FAIL hold_irq_k%0d got=%b exp=%b", c, bus.irq, exp_irq[c]); end
      if (c == 2) begin
        n_vec++; if (bus.irq_status !== 5'b00001) begin n_err++; $display("FAIL hold_reset_status got=%b exp=00001", bus.irq_status); end
      end
    end
    bus.event_in = 5'b00000;
  endtask

  task automatic test_set_wins();
    bus.event_in  = 5'b00100;
    bus.clr_valid = 1'b1;
    bus.clr_data  = 5'b00100;
    tick();
    idle_inputs();
    n_vec++; if (bus.irq_status !== 5'b00101) begin n_err++; $display("FAIL setwins_status got=%b exp=00101", bus.irq_status); end
    bus.clr_data = 5'b11111;
    tick();
    idle_inputs();
    n_vec++; if (bus.irq_status !== 5'b00101) begin n_err++; $display("FAIL clr_novalid got=%b exp=00101", bus.irq_status); end
    n_vec++; if (bus.irq !== 1'b1) begin n_err++; $display("FAIL setwins_irq got=%b exp=1", bus.irq); end
    quiesce();
  endtask

  task automatic test_event_cnt();
    logic [39:0] exp_sat;
    logic [39:0] exp_one;
`ifdef CFS_IRQ_EVENT_CNT_EN
    exp_sat = 40'h00_0000_FF00;
    exp_one = 40'h00_0000_0100;
`else
    exp_sat = 40'h0;
    exp_one = 40'h0;
`endif
    bus.event_in = 5'b00010;
    tick(300);
    bus.event_in = 5'b00000;
    n_vec++; if (bus.event_cnt !== exp_sat) begin n_err++; $display("FAIL cnt_saturate got=%h exp=%h", bus.event_cnt, exp_sat); end
    n_vec++; if (bus.irq_status !== 5'b00010) begin n_err++; $display("FAIL cnt_status got=%b exp=00010", bus.irq_status); end
    n_vec++; if (bus.irq !== 1'b0) begin n_err++; $display("FAIL cnt_irq_masked got=%b exp=0", bus.irq); end
    bus.clr_valid = 1'b1;
    bus.clr_data  = 5'b00010;
    tick();
    idle_inputs();
    n_vec++; if (bus.event_cnt !== 40'h0) begin n_err++; $display("FAIL cnt_w1c got=%h exp=0", bus.event_cnt); end
    bus.event_in  = 5'b00010;
    tick(3);
    bus.clr_valid = 1'b1;
    bus.clr_data  = 5'b00010;
    tick();
    idle_inputs();
    n_vec++; if (bus.event_cnt !== exp_one) begin n_err++; $display("FAIL cnt_w1c_event got=%h exp=%h", bus.event_cnt, exp_one); end
    quiesce();
  endtask

  task automatic test_reset_in_holdoff();
    write_en(5'b11111);
    bus.event_in = 5'b11111;
    tick();
    bus.event_in = 5'b00000;
    tick();
    n_vec++; if (bus.irq !== 1'b1) begin n_err++; $display("FAIL rsth_assert got=%b exp=1", bus.irq); end
    write_en(5'b00000);
    tick();
    n_vec++; if (bus.irq !== 1'b0) begin n_err++; $display("FAIL rsth_holdoff_irq got=%b exp=0", bus.irq); end
    n_vec++; if (bus.irq_status !== 5'b11111) begin n_err++; $display("FAIL rsth_status_pre got=%b exp=11111", bus.irq_status); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_vec++; if (bus.irq_status !== 5'b0) begin n_err++; $display("FAIL rsth_status got=%b exp=00000", bus.irq_status); end
    n_vec++; if (bus.irq_en !== 5'b0) begin n_err++; $display("FAIL rsth_en got=%b exp=00000", bus.irq_en); end
    n_vec++; if (bus.irq !== 1'b0) begin n_err++; $display("FAIL rsth_irq got=%b exp=0", bus.irq); end
    n_vec++; if (bus.event_cnt !== 40'h0) begin n_err++; $display("FAIL rsth_cnt got=%h exp=0", bus.event_cnt); end
    // From IDLE, an event with enable must raise irq two edges later; a stuck hold-off would delay it.
    bus.en_valid = 1'b1;
    bus.en_data  = 5'b00100;
    bus.event_in = 5'b00100;
    tick();
    idle_inputs();
    n_vec++; if (bus.irq !== 1'b0) begin n_err++; $display("FAIL rsth_idle_t1 got=%b exp=0", bus.irq); end
    tick();
    n_vec++; if (bus.irq !== 1'b1) begin n_err++; $display("FAIL rsth_idle_t2 got=%b exp=1", bus.irq); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_basic();
    test_enable_late();
    test_holdoff();
    test_set_wins();
    test_event_cnt();
    test_reset_in_holdoff();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cfs_irq_collector.md
Name: cfs_irq_collector

Overview:
- Downstream consumer of the aligner's edge-detector pulses (FIFO empty/full, max-drop events).
- Latches each one-cycle event into a sticky status bit and masks it with a software enable register.
- Drives one level interrupt `irq` through a small state machine that enforces a hold-off gap after each deassertion.
- Sits between the per-event edge detectors and the APB register file, which performs the enable writes and the write-1-to-clear writes.

Parameters:
- NUM_IRQ, 5, number of event sources and the width of the status and enable vectors.
- HOLDOFF_CYCLES, 4, number of cycles `irq` is forced low after deassertion before it may reassert. Range 0..255.
- CNT_W, 8, width of each per-source event counter. Used only with CFS_IRQ_EVENT_CNT_EN.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- event_in  input  NUM_IRQ  one-cycle event pulses from the edge detectors.
- clr_valid  input  1  qualifies clr_data as a status-clear write.
- clr_data  input  NUM_IRQ  write-1-to-clear mask for irq_status.
- en_valid  input  1  qualifies en_data as an enable-register write.
- en_data  input  NUM_IRQ  new value of irq_en.
- irq_status  output  NUM_IRQ  sticky event status.
- irq_en  output  NUM_IRQ  interrupt enable register.
- irq  output  1  level interrupt to the host.
- event_cnt  output  NUM_IRQ*CNT_W  per-source event counters, source i at bits [i*CNT_W +: CNT_W].

Behaviour:
- Reset (reset=1 at a clk edge): irq_status=0, irq_en=0, irq=0, FSM=IDLE, hold-off counter=0, event_cnt=0.
  - Reset mid-operation (any state, including HOLDOFF) applies the same values on that edge. Pending events are discarded.
- Status bit i:
  - Set on the edge after event_in[i]=1.
  - Cleared on the edge after clr_valid=1 with clr_data[i]=1.
  - If set and clear hit the same cycle, set wins (no event lost).
  - clr_data bits that are 0 have no effect. clr_data is ignored when clr_valid=0.
  - Status sets regardless of irq_en.
- irq_en: loaded with en_data on the edge after en_valid=1, otherwise held. clr and en writes in the same cycle are independent.
- pending = OR of (irq_status AND irq_en), computed from registered values.
- FSM, with registered output irq:
  - IDLE: irq=0. If pending, go to ASSERT.
  - ASSERT: irq=1. If !pending:
    - HOLDOFF_CYCLES=0: go directly to IDLE.
    - Otherwise: go to HOLDOFF and load counter=HOLDOFF_CYCLES-1.
  - HOLDOFF: irq=0 for exactly HOLDOFF_CYCLES cycles, counter decrementing. When counter=0, go to IDLE. pending is ignored during HOLDOFF.
- Latency:
  - event_in at cycle t, enable already set: irq_status at t+1, irq=1 at t+2.
  - Enabling an already-set status bit: irq at write+2.
  - W1C of the last pending bit: irq=0 at write+2.
- An enable cleared while in ASSERT counts as pending dropping; the normal ASSERT to HOLDOFF/IDLE path applies.
- Holding event_in high for several cycles keeps the status bit set, with no other effect.

Optional Feature:
- Macro: CFS_IRQ_EVENT_CNT_EN.
- Defined:
  - event_cnt[i] increments on each cycle event_in[i]=1 and saturates at 2^CNT_W-1 (no wrap).
  - It resets to 0 on the edge of a W1C of status bit i, unless event_in[i]=1 in the same cycle, in which case it loads 1.
- Not defined: event_cnt is tied to all zeros, no counter flops are instantiated, and the port remains present.

Test Plan:
- Reset, irq_en=5'b00001, pulse event_in=5'b00001 at cycle 10 -> irq_status=5'b00001 at 11, irq=1 at 12.
- irq_en=0, pulse event_in[3] -> irq_status=5'b01000, irq stays 0. Then write en_data=5'b01000 -> irq=1 two cycles after the write.
- In ASSERT, clr_data=5'b00001 with clr_valid -> irq=0 for exactly 4 cycles. Event_in[0] re-pulsed during hold-off -> status sets immediately, irq reasserts at the first cycle after hold-off plus 1 (IDLE to ASSERT).
- event_in[2] and clr_data[2] in the same cycle -> irq_status[2] stays 1.
- CFS_IRQ_EVENT_CNT_EN defined, 300 pulses on event_in[1] -> event_cnt[15:8]=255. After W1C of bit 1 -> 0.
- reset asserted while in HOLDOFF with status=5'b11111 -> all outputs 0 on the next edge. FSM in IDLE.
